// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave receiver: FSM states, default codec
// address and bus-level bit constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_BYTE1,
    S_ACK1,
    S_BYTE2,
    S_ACK2,
    S_IGNORE
  } state_e;

  localparam logic [6:0] CODEC_ADDR = 7'h1A;
  localparam logic       ACK_BIT    = 1'b0;
  localparam logic       NACK_BIT   = 1'b1;
  localparam logic       RW_WRITE   = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCLK/SDIN into the system clock domain and flags SCLK edges
// plus START/STOP conditions from the synchronised values only.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [1:0] form the 2-flop synchroniser, [2] holds the previous synchronised value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C slave: ACKs its address and two data bytes, then publishes
// them as a 16-bit MESSAGE with a one-cycle MESSAGE_VALID pulse.
module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = CODEC_ADDR
) (
  input  logic        CLOCK50M,
  input  logic        RESET,
  input  logic        SCLK,
  input  logic        SDIN,
  output logic        SDA_PULL_LOW,
  output logic [15:0] MESSAGE,
  output logic        MESSAGE_VALID,
  output logic        BUSY
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk_i      (CLOCK50M),
    .rst_i      (RESET),
    .scl_i      (SCLK),
    .sda_i      (SDIN),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [15:0] msg_q, msg_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [7:0]  shift_next;

  always_ff @(posedge CLOCK50M or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      byte1_q <= '0;
      msg_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      byte1_q <= byte1_d;
      msg_q   <= msg_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign shift_next = {shift_q[6:0], sda_s};

  // done_q marks "8 bits in, waiting for the SCLK fall that opens the ACK slot"
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    byte1_d = byte1_q;
    msg_d   = msg_q;
    valid_d = 1'b0;
    done_d  = done_q;
    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      shift_d = '0;
      done_d  = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (done_q) begin
            if (scl_fall) begin
              done_d = 1'b0;
              if (state_q == S_ADDR) begin
                state_d = S_ADDR_ACK;
              end else if (state_q == S_BYTE1) begin
                state_d = S_ACK1;
                byte1_d = shift_q;
              end else begin
                state_d = S_ACK2;
                msg_d   = {byte1_q, shift_q};
                valid_d = 1'b1;
              end
            end
          end else if (scl_rise) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == S_ADDR &&
                  !(shift_next[7:1] == SLAVE_ADDR && shift_next[0] == RW_WRITE)) begin
                state_d = S_IGNORE;
              end else begin
                done_d = 1'b1;
              end
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) state_d = S_BYTE1;
        S_ACK1:     if (scl_fall) state_d = S_BYTE2;
        S_ACK2:     if (scl_fall) state_d = S_IGNORE;
        default: ;
      endcase
    end
  end

  assign SDA_PULL_LOW  = (state_q == S_ADDR_ACK) || (state_q == S_ACK1) || (state_q == S_ACK2);
  assign BUSY          = (state_q == S_ADDR_ACK) || (state_q == S_BYTE1) ||
                         (state_q == S_ACK1) || (state_q == S_BYTE2) || (state_q == S_ACK2);
  assign MESSAGE       = msg_q;
  assign MESSAGE_VALID = valid_q;

endmodule

// File: doc/i2c_slave_receiver.md
I2C_SLAVE_RECEIVER -- requirements
Module: i2c_slave_receiver

Interface
REQ-001 Parameter: SLAVE_ADDR, 7'h1A, 7-bit target address (bus write byte 8'h34).
REQ-002 Port: CLOCK50M  input  1  system clock; all internal logic on rising edge.
REQ-003 Port: RESET  input  1  reset; asynchronous, active-high.
REQ-004 Port: SCLK  input  1  I2C clock line as seen at the pin (asynchronous to CLOCK50M).
REQ-005 Port: SDIN  input  1  I2C data line as seen at the pin (asynchronous).
REQ-006 Port: SDA_PULL_LOW  output  1  1 = drive SDA low (open-drain enable); 0 = release.
REQ-007 Port: MESSAGE  output  16  last complete received word, {byte1, byte2}.
REQ-008 Port: MESSAGE_VALID  output  1  one-cycle pulse when MESSAGE updates.
REQ-009 Port: BUSY  output  1  1 from an addressed START until STOP or abort.

Function
REQ-010 SCLK and SDIN SHALL each pass through a 2-flop synchroniser; every edge decision SHALL use the synchronised values only.
REQ-011 START SHALL be detected as a synchronised SDIN falling edge while synchronised SCLK is 1; STOP as an SDIN rising edge while SCLK is 1.
REQ-012 Data bits SHALL be sampled on the synchronised SCLK rising edge, MSB first.
REQ-013 The FSM SHALL have the states IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
REQ-014 IDLE -> ADDR on START; all other inputs are ignored in IDLE.
REQ-015 ADDR SHALL shift 8 bits.
REQ-016 If bits[7:1] == SLAVE_ADDR and bit[0] == 0, the FSM SHALL enter ADDR_ACK.
REQ-017 Otherwise (address mismatch, or a read request) the FSM SHALL enter IGNORE without ACK.
REQ-018 ACK timing: SDA_PULL_LOW SHALL assert on the synchronised SCLK falling edge after the 8th bit.
REQ-019 SDA_PULL_LOW SHALL release on the next synchronised SCLK falling edge, which ends the ACK clock.
REQ-020 The sequence SHALL be ADDR_ACK -> BYTE1 -> ACK1 -> BYTE2 -> ACK2; every byte is ACKed.
REQ-021 On entry to ACK2, MESSAGE SHALL load {byte1, byte2} and MESSAGE_VALID SHALL pulse for exactly 1 CLOCK50M cycle, in the same cycle SDA_PULL_LOW asserts.
REQ-022 After ACK2 the FSM SHALL enter IGNORE; further bytes SHALL be NACKed and SHALL not alter MESSAGE.
REQ-023 BUSY SHALL be 1 in ADDR_ACK through ACK2 and 0 in IDLE, ADDR and IGNORE.
REQ-024 STOP in any state SHALL release SDA and return the FSM to IDLE.
REQ-025 A STOP mid-byte SHALL discard the partial word with no MESSAGE_VALID.
REQ-026 A repeated START in any state SHALL release SDA, clear the bit counter and enter ADDR.
REQ-027 The bit counter SHALL be 3 bits; it SHALL wrap to 0 after the 8th bit and never count past 7.
REQ-028 START/STOP detection SHALL take priority over data sampling in the same cycle.
REQ-029 SDA_PULL_LOW SHALL never assert outside the ADDR_ACK, ACK1 and ACK2 windows.

Reset
REQ-030 While RESET = 1 the FSM SHALL be IDLE.
REQ-031 While RESET = 1: SDA_PULL_LOW = 0, MESSAGE = 16'h0000, MESSAGE_VALID = 0, BUSY = 0.
REQ-032 While RESET = 1 the shift register and bit counter SHALL be 0, and the synchronisers SHALL be 1 (idle bus).
REQ-033 Reset asserted mid-transfer SHALL release SDA asynchronously, within the same cycle.
REQ-034 After reset deasserts, the block SHALL wait for a fresh START.

Structure
REQ-035 Shared package i2c_pkg SHALL hold the FSM state enum, the default codec address constant 7'h1A, and the ACK/NACK bit constants.
REQ-036 One sub-module, i2c_line_sync, SHALL hold the synchronisers and SCLK-rise, SCLK-fall, START and STOP detection.

Verification
REQ-037 Bench SHALL cover: START, 0x34, 0x1E, 0x00, STOP at 100 kHz -> 3 ACKs; MESSAGE = 16'h1E00; one MESSAGE_VALID pulse; BUSY falls at STOP.
REQ-038 Bench SHALL cover: START, 0x36, 0x12, STOP -> no ACK on any byte, MESSAGE unchanged, no MESSAGE_VALID.
REQ-039 Bench SHALL cover: START, 0x35 (read) -> NACK, FSM in IGNORE, SDA_PULL_LOW stays 0 until STOP.
REQ-040 Bench SHALL cover: START, 0x34, 0xAB, STOP -> 2 ACKs, no MESSAGE_VALID, FSM IDLE.
REQ-041 Bench SHALL cover: START, 0x34, 0x0C, repeated START, 0x34, 0x0C, 0x10, STOP -> MESSAGE = 16'h0C10, exactly one pulse.
REQ-042 Bench SHALL cover: RESET during the ACK1 low drive -> SDA_PULL_LOW = 0 the same cycle, all outputs at reset values.
